hm_conbusn: RTL and testbench

- Parametrised N-master to 1-slave arbiter/mux for the TRN transmit interface; successor of the fixed 5-master transmit arbiter.
- Sits between the TLP-generating masters (DMA, config, message engines) and the PCIe endpoint transmit port.
- Packet-aware round-robin: grant locked from accepted tsof to accepted teof, so packets never interleave.
- Re-arbitration at packet boundaries with zero idle cycles.

---
 rtl/hm_conbusn.sv | 216 +++++++++++++++++++++
 tb/tb_hm_conbusn.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hm_conbusn.sv
// hm_conbusn: N-master to 1-slave TRN transmit arbiter/mux.
// Packet-aware round-robin: the grant is locked from an accepted tsof
// to an accepted teof (or abort), and re-arbitration at a packet
// boundary hands over with no idle cycle.
// Optional build macro HM_CONBUSN_PRIO0_EN: master 0 wins every
// arbitration point while it requests (last is still updated).
module hm_conbusn #(
  parameter int NM = 5,
  parameter int DW = 64,
  parameter int RW = 1,
  parameter int GW = 3
) (
  input  logic             trn_clk,
  input  logic             trn_rst,
  input  logic [NM-1:0]    m_trn_cyc_n,
  input  logic [NM*DW-1:0] m_trn_td,
  input  logic [NM*RW-1:0] m_trn_trem_n,
  input  logic [NM-1:0]    m_trn_tsof_n,
  input  logic [NM-1:0]    m_trn_teof_n,
  input  logic [NM-1:0]    m_trn_tsrc_rdy_n,
  input  logic [NM-1:0]    m_trn_tsrc_dsc_n,
  input  logic [NM-1:0]    m_trn_terrfwd_n,
  input  logic [NM-1:0]    m_trn_tstr_n,
  output logic [NM-1:0]    m_trn_tdst_rdy_n,
  output logic [5:0]       m_trn_tbuf_av,
  output logic             m_trn_terr_drop_n,
  input  logic [5:0]       s_trn_tbuf_av,
  input  logic             s_trn_terr_drop_n,
  input  logic             s_trn_tdst_rdy_n,
  output logic [DW-1:0]    s_trn_td,
  output logic [RW-1:0]    s_trn_trem_n,
  output logic             s_trn_tsof_n,
  output logic             s_trn_teof_n,
  output logic             s_trn_tsrc_rdy_n,
  output logic             s_trn_tsrc_dsc_n,
  output logic             s_trn_terrfwd_n,
  output logic             s_trn_tstr_n,
  output logic [GW-1:0]    gnt,
  output logic             gnt_vld
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_gnt, w_gnt_nxt;
  logic [GW-1:0]   r_last, w_last_nxt;
  logic            r_gnt_vld, w_gnt_vld_nxt;
  logic            r_in_pkt, w_in_pkt_nxt;
  logic [GW-1:0]   w_pick;
  logic [NM-1:0]   w_req;
  logic            w_any_req, w_acc, w_boundary, w_pkt_upd;

  logic [DW-1:0]   w_own_td;
  logic [RW-1:0]   w_own_trem_n;
  logic            w_own_cyc_n, w_own_sof_n, w_own_eof_n, w_own_rdy_n;
  logic            w_own_dsc_n, w_own_errfwd_n, w_own_str_n;

  // Round-robin choice: first requester after 'last', previous owner checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [NM-1:0] req,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = {GW{1'b0}};
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = int'(last) + k;
      if (idx >= NM) idx = idx - NM;
      else           idx = idx;
      for (int j = 0; j < NM; j++) begin
        if (!found && req[j] && (idx == j)) begin
          pick  = GW'(j);
          found = 1'b1;
        end else begin
          pick  = pick;
        end
      end
    end
`ifdef HM_CONBUSN_PRIO0_EN
    if (req[0]) pick = {GW{1'b0}};
    else        pick = pick;
`endif
    return pick;
  endfunction

  assign w_req     = ~m_trn_cyc_n;
  assign w_any_req = |w_req;
  assign w_pick    = rr_pick(w_req, r_last);

  assign gnt               = r_gnt;
  assign gnt_vld           = r_gnt_vld;
  assign m_trn_tbuf_av     = s_trn_tbuf_av;
  assign m_trn_terr_drop_n = s_trn_terr_drop_n;

  // Owner slice select; an unmatched index falls back to master NM-1.
  always_comb begin
    w_own_td       = m_trn_td[(NM-1)*DW +: DW];
    w_own_trem_n   = m_trn_trem_n[(NM-1)*RW +: RW];
    w_own_cyc_n    = m_trn_cyc_n[NM-1];
    w_own_sof_n    = m_trn_tsof_n[NM-1];
    w_own_eof_n    = m_trn_teof_n[NM-1];
    w_own_rdy_n    = m_trn_tsrc_rdy_n[NM-1];
    w_own_dsc_n    = m_trn_tsrc_dsc_n[NM-1];
    w_own_errfwd_n = m_trn_terrfwd_n[NM-1];
    w_own_str_n    = m_trn_tstr_n[NM-1];
    for (int i = 0; i < NM - 1; i++) begin
      w_own_td       = (r_gnt == GW'(i)) ? m_trn_td[i*DW +: DW]     : w_own_td;
      w_own_trem_n   = (r_gnt == GW'(i)) ? m_trn_trem_n[i*RW +: RW] : w_own_trem_n;
      w_own_cyc_n    = (r_gnt == GW'(i)) ? m_trn_cyc_n[i]           : w_own_cyc_n;
      w_own_sof_n    = (r_gnt == GW'(i)) ? m_trn_tsof_n[i]          : w_own_sof_n;
      w_own_eof_n    = (r_gnt == GW'(i)) ? m_trn_teof_n[i]          : w_own_eof_n;
      w_own_rdy_n    = (r_gnt == GW'(i)) ? m_trn_tsrc_rdy_n[i]      : w_own_rdy_n;
      w_own_dsc_n    = (r_gnt == GW'(i)) ? m_trn_tsrc_dsc_n[i]      : w_own_dsc_n;
      w_own_errfwd_n = (r_gnt == GW'(i)) ? m_trn_terrfwd_n[i]       : w_own_errfwd_n;
      w_own_str_n    = (r_gnt == GW'(i)) ? m_trn_tstr_n[i]          : w_own_str_n;
    end
  end

  // Slave-side mux: owner's bus when granted, idle values otherwise.
  always_comb begin
    if (r_gnt_vld) begin
      s_trn_td         = w_own_td;
      s_trn_trem_n     = w_own_trem_n;
      s_trn_tsof_n     = w_own_sof_n;
      s_trn_teof_n     = w_own_eof_n;
      s_trn_tsrc_rdy_n = w_own_rdy_n;
      s_trn_tsrc_dsc_n = w_own_dsc_n;
      s_trn_terrfwd_n  = w_own_errfwd_n;
      s_trn_tstr_n     = w_own_str_n;
    end else begin
      s_trn_td         = {DW{1'b0}};
      s_trn_trem_n     = {RW{1'b1}};
      s_trn_tsof_n     = 1'b1;
      s_trn_teof_n     = 1'b1;
      s_trn_tsrc_rdy_n = 1'b1;
      s_trn_tsrc_dsc_n = 1'b1;
      s_trn_terrfwd_n  = 1'b1;
      s_trn_tstr_n     = 1'b1;
    end
  end

  // Destination ready is routed back to the owner only.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_trn_tdst_rdy_n[i] = s_trn_tdst_rdy_n | ~(r_gnt_vld & (r_gnt == GW'(i)));
    end
  end

  assign w_acc      = r_gnt_vld & ~s_trn_tsrc_rdy_n & ~s_trn_tdst_rdy_n;
  assign w_boundary = w_acc & (~w_own_eof_n | ~w_own_dsc_n);

  // Arbitration FSM next state, grant and packet tracking.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_vld_nxt = r_gnt_vld;
    w_last_nxt    = r_last;
    w_in_pkt_nxt  = r_in_pkt;
    if (w_boundary)                w_pkt_upd = 1'b0;
    else if (w_acc & ~w_own_sof_n) w_pkt_upd = 1'b1;
    else                           w_pkt_upd = r_in_pkt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt   = ST_OWN;
          w_gnt_nxt     = w_pick;
          w_gnt_vld_nxt = 1'b1;
          w_last_nxt    = w_pick;
          w_in_pkt_nxt  = 1'b0;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (w_boundary | (~w_pkt_upd & w_own_cyc_n)) begin
          w_in_pkt_nxt = 1'b0;
          if (w_any_req) begin
            w_gnt_nxt     = w_pick;
            w_gnt_vld_nxt = 1'b1;
            w_last_nxt    = w_pick;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_gnt_vld_nxt = 1'b0;
          end
        end else begin
          w_in_pkt_nxt = w_pkt_upd;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_nxt     = {GW{1'b0}};
        w_gnt_vld_nxt = 1'b0;
        w_last_nxt    = GW'(NM - 1);
        w_in_pkt_nxt  = 1'b0;
      end
    endcase
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge trn_clk) begin
    if (trn_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= {GW{1'b0}};
      r_gnt_vld <= 1'b0;
      r_in_pkt  <= 1'b0;
      r_last    <= GW'(NM - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_in_pkt  <= w_in_pkt_nxt;
      r_last    <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_hm_conbusn.sv
// Directed testbench for hm_conbusn (NM=5, DW=64, RW=1, GW=3).
module tb_hm_conbusn;
  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   cyc_n, tsof_n, teof_n, rdy_n, dsc_n, errfwd_n, tstr_n;
  logic [319:0] td;
  logic [4:0]   trem_n;
  logic [4:0]   m_tdst_rdy_n;
  logic [5:0]   m_tbuf_av, s_tbuf_av;
  logic         m_terr_drop_n, s_terr_drop_n, s_tdst_rdy_n;
  logic [63:0]  s_td;
  logic [0:0]   s_trem_n;
  logic         s_tsof_n, s_teof_n, s_tsrc_rdy_n, s_tsrc_dsc_n, s_terrfwd_n, s_tstr_n;
  logic [2:0]   gnt;
  logic         gnt_vld;
  int           nvec = 0;
  int           nerr = 0;

  hm_conbusn #(.NM(5), .DW(64), .RW(1), .GW(3)) dut (
    .trn_clk(clk), .trn_rst(rst),
    .m_trn_cyc_n(cyc_n), .m_trn_td(td), .m_trn_trem_n(trem_n),
    .m_trn_tsof_n(tsof_n), .m_trn_teof_n(teof_n), .m_trn_tsrc_rdy_n(rdy_n),
    .m_trn_tsrc_dsc_n(dsc_n), .m_trn_terrfwd_n(errfwd_n), .m_trn_tstr_n(tstr_n),
    .m_trn_tdst_rdy_n(m_tdst_rdy_n), .m_trn_tbuf_av(m_tbuf_av),
    .m_trn_terr_drop_n(m_terr_drop_n),
    .s_trn_tbuf_av(s_tbuf_av), .s_trn_terr_drop_n(s_terr_drop_n),
    .s_trn_tdst_rdy_n(s_tdst_rdy_n),
    .s_trn_td(s_td), .s_trn_trem_n(s_trem_n), .s_trn_tsof_n(s_tsof_n),
    .s_trn_teof_n(s_teof_n), .s_trn_tsrc_rdy_n(s_tsrc_rdy_n),
    .s_trn_tsrc_dsc_n(s_tsrc_dsc_n), .s_trn_terrfwd_n(s_terrfwd_n),
    .s_trn_tstr_n(s_tstr_n), .gnt(gnt), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dat(input int m, input int b);
    return {16'hA5A5, 16'(m), 32'(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    tsof_n = 5'h1F; teof_n = 5'h1F; rdy_n = 5'h1F; dsc_n = 5'h1F;
    errfwd_n = 5'h1F; tstr_n = 5'h1F; td = '0; trem_n = 5'h1F;
  endtask

  task automatic beat(input int m, input logic sof, input logic eof,
                      input logic dsc, input logic [63:0] d);
    rdy_n[m] = 1'b0; tsof_n[m] = ~sof; teof_n[m] = ~eof; dsc_n[m] = ~dsc;
    td[m*64 +: 64] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr(); cyc_n = 5'h1F; s_tdst_rdy_n = 1'b1;
    s_tbuf_av = 6'h2A; s_terr_drop_n = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL rst_gnt_vld got %0b exp 0", gnt_vld); end
    nvec++; if (gnt !== 3'd0) begin nerr++; $display("FAIL rst_gnt got %0d exp 0", gnt); end
    nvec++; if (s_tsrc_rdy_n !== 1'b1 || s_td !== 64'd0 || s_trem_n !== 1'b1) begin nerr++; $display("FAIL rst_idle rdy=%0b td=%h trem=%0b exp 1/0/1", s_tsrc_rdy_n, s_td, s_trem_n); end
    nvec++; if (m_tdst_rdy_n !== 5'h1F) begin nerr++; $display("FAIL rst_dst_rdy got %b exp 11111", m_tdst_rdy_n); end
    nvec++; if (m_tbuf_av !== 6'h2A || m_terr_drop_n !== 1'b0) begin nerr++; $display("FAIL bcast got %h/%0b exp 2a/0", m_tbuf_av, m_terr_drop_n); end
    s_terr_drop_n = 1'b1; #1;
    nvec++; if (m_terr_drop_n !== 1'b1) begin nerr++; $display("FAIL bcast_drop got %0b exp 1", m_terr_drop_n); end
  endtask

  task automatic test_single_master();
    step(); clr(); cyc_n = 5'b11110; #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL m0_latency gnt_vld got %0b exp 0", gnt_vld); end
    for (int b = 0; b < 3; b++) begin
      step(); clr(); cyc_n = (b == 2) ? 5'h1F : 5'b11110; s_tdst_rdy_n = 1'b0;
      beat(0, b == 0, b == 2, 1'b0, dat(0, b));
      if (b == 2) trem_n[0] = 1'b0;
      #1;
      nvec++; if (gnt_vld !== 1'b1 || gnt !== 3'd0) begin nerr++; $display("FAIL m0_gnt beat%0d got %0b/%0d exp 1/0", b, gnt_vld, gnt); end
      nvec++; if (s_td !== dat(0, b)) begin nerr++; $display("FAIL m0_td beat%0d got %h exp %h", b, s_td, dat(0, b)); end
      nvec++; if (s_tsof_n !== (b != 0) || s_teof_n !== (b != 2)) begin nerr++; $display("FAIL m0_sof_eof beat%0d got %0b%0b", b, s_tsof_n, s_teof_n); end
      nvec++; if (m_tdst_rdy_n !== 5'b11110) begin nerr++; $display("FAIL m0_dst_rdy got %b exp 11110", m_tdst_rdy_n); end
      nvec++; if (s_trem_n !== ((b == 2) ? 1'b0 : 1'b1)) begin nerr++; $display("FAIL m0_trem beat%0d got %0b", b, s_trem_n); end
    end
    step(); clr(); #1;
    nvec++; if (gnt_vld !== 1'b0 || s_tsrc_rdy_n !== 1'b1 || s_td !== 64'd0) begin nerr++; $display("FAIL m0_idle got vld=%0b rdy=%0b td=%h", gnt_vld, s_tsrc_rdy_n, s_td); end
  endtask

  task automatic test_back_to_back();
    int exp_m[4] = '{1, 3, 1, 3};
    step(); clr(); cyc_n = 5'b10101; #1;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 2; b++) begin
        step(); clr(); cyc_n = (p == 3 && b == 1) ? 5'h1F : 5'b10101; s_tdst_rdy_n = 1'b0;
        beat(exp_m[p], b == 0, b == 1, 1'b0, dat(exp_m[p], p * 2 + b));
        #1;
        nvec++; if (gnt_vld !== 1'b1 || gnt !== 3'(exp_m[p])) begin nerr++; $display("FAIL b2b_gnt pkt%0d beat%0d got %0b/%0d exp 1/%0d", p, b, gnt_vld, gnt, exp_m[p]); end
        nvec++; if (s_td !== dat(exp_m[p], p * 2 + b)) begin nerr++; $display("FAIL b2b_td pkt%0d got %h exp %h", p, s_td, dat(exp_m[p], p * 2 + b)); end
      end
    end
    step(); clr(); #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL b2b_idle got %0b exp 0", gnt_vld); end
  endtask

  task automatic test_stall_hold();
    step(); clr(); cyc_n = 5'b11011; #1;
    step(); clr(); cyc_n = 5'b11011; s_tdst_rdy_n = 1'b0; beat(2, 1'b1, 1'b0, 1'b0, dat(2, 0)); #1;
    nvec++; if (gnt !== 3'd2 || gnt_vld !== 1'b1) begin nerr++; $display("FAIL hold_first got %0d/%0b exp 2/1", gnt, gnt_vld); end
    for (int c = 0; c < 5; c++) begin
      step(); clr(); cyc_n = 5'b11110; s_tdst_rdy_n = (c < 4) ? 1'b1 : 1'b0;
      beat(2, 1'b0, 1'b0, 1'b0, dat(2, 1)); #1;
      nvec++; if (gnt !== 3'd2) begin nerr++; $display("FAIL hold_gnt cyc%0d got %0d exp 2", c, gnt); end
      nvec++; if (m_tdst_rdy_n !== ((c < 4) ? 5'b11111 : 5'b11011)) begin nerr++; $display("FAIL hold_dst_rdy cyc%0d got %b", c, m_tdst_rdy_n); end
    end
    step(); clr(); cyc_n = 5'b11110; s_tdst_rdy_n = 1'b0; beat(2, 1'b0, 1'b1, 1'b0, dat(2, 2)); #1;
    nvec++; if (gnt !== 3'd2 || m_tdst_rdy_n[0] !== 1'b1 || s_teof_n !== 1'b0) begin nerr++; $display("FAIL hold_eof got gnt=%0d rdy0=%0b eof=%0b", gnt, m_tdst_rdy_n[0], s_teof_n); end
  endtask

  task automatic test_abort();
    step(); clr(); cyc_n = 5'b11100; s_tdst_rdy_n = 1'b0; beat(0, 1'b1, 1'b0, 1'b0, dat(0, 7)); #1;
    nvec++; if (gnt !== 3'd0 || gnt_vld !== 1'b1 || s_tsof_n !== 1'b0) begin nerr++; $display("FAIL abort_owner got %0d/%0b sof=%0b exp 0/1/0", gnt, gnt_vld, s_tsof_n); end
    step(); clr(); cyc_n = 5'b11101; beat(0, 1'b0, 1'b0, 1'b1, dat(0, 8)); #1;
    nvec++; if (gnt !== 3'd0 || s_tsrc_dsc_n !== 1'b0) begin nerr++; $display("FAIL abort_beat got %0d dsc=%0b exp 0/0", gnt, s_tsrc_dsc_n); end
    step(); clr(); cyc_n = 5'h1F; beat(1, 1'b1, 1'b1, 1'b0, dat(1, 9)); #1;
    nvec++; if (gnt !== 3'd1 || gnt_vld !== 1'b1) begin nerr++; $display("FAIL abort_next got %0d/%0b exp 1/1", gnt, gnt_vld); end
    nvec++; if (s_td !== dat(1, 9)) begin nerr++; $display("FAIL abort_next_td got %h exp %h", s_td, dat(1, 9)); end
    step(); clr(); #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL single_beat_idle got %0b exp 0", gnt_vld); end
  endtask

  task automatic test_reset_mid_pkt();
    step(); clr(); cyc_n = 5'b01111; #1;
    step(); clr(); s_tdst_rdy_n = 1'b0; beat(4, 1'b1, 1'b0, 1'b0, dat(4, 0)); #1;
    nvec++; if (gnt !== 3'd4 || gnt_vld !== 1'b1) begin nerr++; $display("FAIL rstpkt_gnt got %0d/%0b exp 4/1", gnt, gnt_vld); end
    step(); clr(); beat(4, 1'b0, 1'b0, 1'b0, dat(4, 1)); rst = 1'b1; #1;
    step(); rst = 1'b0; clr(); beat(4, 1'b0, 1'b0, 1'b0, dat(4, 2)); cyc_n = 5'b00110; #1;
    nvec++; if (gnt_vld !== 1'b0 || gnt !== 3'd0) begin nerr++; $display("FAIL rstpkt_state got %0b/%0d exp 0/0", gnt_vld, gnt); end
    nvec++; if (s_tsrc_rdy_n !== 1'b1 || s_td !== 64'd0) begin nerr++; $display("FAIL rstpkt_idle got rdy=%0b td=%h exp 1/0", s_tsrc_rdy_n, s_td); end
    step(); clr(); cyc_n = 5'h1F; #1;
    nvec++; if (gnt !== 3'd0 || gnt_vld !== 1'b1) begin nerr++; $display("FAIL rstpkt_first got %0d/%0b exp 0/1", gnt, gnt_vld); end
    step(); #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL rstpkt_release got %0b exp 0", gnt_vld); end
  endtask

  task automatic test_prio0();
`ifdef HM_CONBUSN_PRIO0_EN
    int exp_m[4] = '{0, 0, 0, 0};
`else
    int exp_m[4] = '{0, 1, 0, 1};
`endif
    rst = 1'b1; step(); rst = 1'b0; clr(); cyc_n = 5'b11100; #1;
    for (int p = 0; p < 4; p++) begin
      step(); clr(); cyc_n = (p == 3) ? 5'h1F : 5'b11100; s_tdst_rdy_n = 1'b0;
      beat(exp_m[p], 1'b1, 1'b1, 1'b0, dat(exp_m[p], 20 + p)); #1;
      nvec++; if (gnt_vld !== 1'b1 || gnt !== 3'(exp_m[p])) begin nerr++; $display("FAIL prio_gnt pkt%0d got %0b/%0d exp 1/%0d", p, gnt_vld, gnt, exp_m[p]); end
    end
    step(); clr(); #1;
    nvec++; if (gnt_vld !== 1'b0) begin nerr++; $display("FAIL prio_idle got %0b exp 0", gnt_vld); end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_back_to_back();
    test_stall_hold();
    test_abort();
    test_reset_mid_pkt();
    test_prio0();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
